// File: rtl/grey_conv_if.sv
// Parallel video bus: data enable, syncs and one RGB888 pixel per clock.
// The source drives through master and the sink receives through slave.
interface grey_conv_if;
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (output de, hs, vs, r, g, b);
    modport slave  (input  de, hs, vs, r, g, b);
endinterface

// File: rtl/grey_conv.sv
// Three-stage RGB888 to luma stage with frame-synchronous mode switching.
// Syncs, data enable and the per-pixel mode travel down the pipe with the pixel.
module grey_conv #(
    parameter int unsigned AUTO_FRAMES = 60,
    parameter bit          VS_POL      = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  mode_i,
    grey_conv_if.slave  vid_i,
    grey_conv_if.master vid_o,
    output logic [1:0]  mode_o,
    output logic        frame_tgl_o
);

    localparam int unsigned CntW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(AUTO_FRAMES - 1);

    localparam logic [1:0] ModeGrey = 2'd1;
    localparam logic [1:0] ModeAuto = 2'd2;
    localparam logic [1:0] ModeInv  = 2'd3;

    // Frame control
    logic            vs_act, vs_act_q, frame_start;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic [1:0]      mode_q, mode_d;
    logic            tgl_q, tgl_d;

    // Pipeline stages
    logic        de1_q, hs1_q, vs1_q, de2_q, hs2_q, vs2_q, de3_q, hs3_q, vs3_q;
    logic [7:0]  r1_q, g1_q, b1_q, r2_q, g2_q, b2_q, r3_q, g3_q, b3_q;
    logic [7:0]  r3_d, g3_d, b3_d;
    logic [1:0]  mode1_q, mode2_q, mode3_q;
    logic [15:0] pr1_q, pg1_q, pb1_q;
    logic [16:0] sum2_q;
    logic [16:0] y_full;
    logic [7:0]  y, y_inv;

    assign vs_act      = (vid_i.vs == VS_POL);
    assign frame_start = vs_act & ~vs_act_q;

    // The mode loaded at a boundary already sees the post-wrap auto select.
    always_comb begin
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        mode_d = mode_q;
        tgl_d  = tgl_q;
        if (frame_start) begin
            tgl_d = ~tgl_q;
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                sel_d = ~sel_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
            mode_d = (mode_i == ModeAuto) ? {1'b0, sel_d} : mode_i;
        end
    end

    always_comb begin
        y_full = sum2_q >> 8;
        y      = (y_full > 17'd255) ? 8'hFF : y_full[7:0];
        y_inv  = 8'hFF - y;
        r3_d   = '0;
        g3_d   = '0;
        b3_d   = '0;
        if (de2_q) begin
            case (mode2_q)
                ModeGrey: begin
                    r3_d = y;
                    g3_d = y;
                    b3_d = y;
                end
                ModeInv: begin
                    r3_d = y_inv;
                    g3_d = y_inv;
                    b3_d = y_inv;
                end
                default: begin
                    r3_d = r2_q;
                    g3_d = g2_q;
                    b3_d = b2_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs_act_q <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            mode_q   <= '0;
            tgl_q    <= 1'b0;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            r1_q     <= '0;
            g1_q     <= '0;
            b1_q     <= '0;
            mode1_q  <= '0;
            pr1_q    <= '0;
            pg1_q    <= '0;
            pb1_q    <= '0;
            de2_q    <= 1'b0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            r2_q     <= '0;
            g2_q     <= '0;
            b2_q     <= '0;
            mode2_q  <= '0;
            sum2_q   <= '0;
            de3_q    <= 1'b0;
            hs3_q    <= 1'b0;
            vs3_q    <= 1'b0;
            r3_q     <= '0;
            g3_q     <= '0;
            b3_q     <= '0;
            mode3_q  <= '0;
        end else begin
            vs_act_q <= vs_act;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            tgl_q    <= tgl_d;
            // Stage 1: mode is bound to the pixel here, so a boundary never tears a pixel.
            de1_q    <= vid_i.de;
            hs1_q    <= vid_i.hs;
            vs1_q    <= vid_i.vs;
            r1_q     <= vid_i.r;
            g1_q     <= vid_i.g;
            b1_q     <= vid_i.b;
            mode1_q  <= mode_d;
            pr1_q    <= 16'(vid_i.r) * 16'd77;
            pg1_q    <= 16'(vid_i.g) * 16'd150;
            pb1_q    <= 16'(vid_i.b) * 16'd29;
            de2_q    <= de1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            r2_q     <= r1_q;
            g2_q     <= g1_q;
            b2_q     <= b1_q;
            mode2_q  <= mode1_q;
            sum2_q   <= 17'(pr1_q) + 17'(pg1_q) + 17'(pb1_q) + 17'd128;
            de3_q    <= de2_q;
            hs3_q    <= hs2_q;
            vs3_q    <= vs2_q;
            r3_q     <= r3_d;
            g3_q     <= g3_d;
            b3_q     <= b3_d;
            mode3_q  <= mode2_q;
        end
    end

    assign vid_o.de    = de3_q;
    assign vid_o.hs    = hs3_q;
    assign vid_o.vs    = vs3_q;
    assign vid_o.r     = r3_q;
    assign vid_o.g     = g3_q;
    assign vid_o.b     = b3_q;
    assign mode_o      = mode3_q;
    assign frame_tgl_o = tgl_q;

endmodule

// File: tb/tb_grey_conv.sv
// Self-checking bench for grey_conv: directed pixels, random timing and modes,
// async reset and auto-mode sequencing against a frame-level reference model.
module tb_grey_conv;

    localparam int AF = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode_i;
    logic [1:0] mode_o;
    logic       frame_tgl_o;

    grey_conv_if vid_in ();
    grey_conv_if vid_out ();

    grey_conv #(
        .AUTO_FRAMES(AF),
        .VS_POL     (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .mode_i     (mode_i),
        .vid_i      (vid_in),
        .vid_o      (vid_out),
        .mode_o     (mode_o),
        .frame_tgl_o(frame_tgl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int de;
        int hs;
        int vs;
        int r;
        int g;
        int b;
        int mode;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: boundaries seen since reset drive the auto select.
    int m_prev_vs, m_nb, m_mode, m_tgl;
    int obs_r, obs_g, obs_b, obs_mode;
    int last_tgl, tgl_changes;
    int exp_auto[8] = '{0, 1, 1, 0, 0, 1, 1, 0};

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int luma(input int r, input int g, input int b);
        int y;
        y = (77 * r + 150 * g + 29 * b + 128) / 256;
        return (y > 255) ? 255 : y;
    endfunction

    task automatic model_apply(input int mode, input int de, input int hs, input int vs,
                               input int r, input int g, input int b);
        pix_t p;
        int   y;
        if (vs != 0 && m_prev_vs == 0) begin
            m_nb++;
            m_tgl  = 1 - m_tgl;
            m_mode = (mode == 2) ? (m_nb / AF) % 2 : mode;
        end
        m_prev_vs = vs;
        y = luma(r, g, b);
        p.de = de; p.hs = hs; p.vs = vs; p.mode = m_mode;
        p.r = 0; p.g = 0; p.b = 0;
        if (de != 0) begin
            if (m_mode == 1) begin
                p.r = y; p.g = y; p.b = y;
            end else if (m_mode == 3) begin
                p.r = 255 - y; p.g = 255 - y; p.b = 255 - y;
            end else begin
                p.r = r; p.g = g; p.b = b;
            end
        end
        exp_q.push_back(p);
    endtask

    task automatic drive(input int mode, input int de, input int hs, input int vs,
                         input int r, input int g, input int b);
        mode_i    = 2'(mode);
        vid_in.de = 1'(de);
        vid_in.hs = 1'(hs);
        vid_in.vs = 1'(vs);
        vid_in.r  = 8'(r);
        vid_in.g  = 8'(g);
        vid_in.b  = 8'(b);
        model_apply(mode, de, hs, vs, r, g, b);
    endtask

    // Called at a falling edge: idle inputs, release reset, reseed the model.
    task automatic release_reset(input int mode);
        pix_t z;
        z = '{0, 0, 0, 0, 0, 0, 0};
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        m_prev_vs = 0; m_nb = 0; m_mode = 0; m_tgl = 0; last_tgl = 0;
        drive(mode, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic step(input int mode, input int de, input int hs, input int vs,
                        input int r, input int g, input int b);
        pix_t e;
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("de_o", int'(vid_out.de), e.de);
        check_val("hs_o", int'(vid_out.hs), e.hs);
        check_val("vs_o", int'(vid_out.vs), e.vs);
        check_val("r_o", int'(vid_out.r), e.r);
        check_val("g_o", int'(vid_out.g), e.g);
        check_val("b_o", int'(vid_out.b), e.b);
        check_val("mode_o", int'(mode_o), e.mode);
        check_val("frame_tgl_o", int'(frame_tgl_o), m_tgl);
        obs_r = int'(vid_out.r); obs_g = int'(vid_out.g); obs_b = int'(vid_out.b);
        obs_mode = int'(mode_o);
        if (int'(frame_tgl_o) != last_tgl) tgl_changes++;
        last_tgl = int'(frame_tgl_o);
        drive(mode, de, hs, vs, r, g, b);
    endtask

    task automatic blanks(input int mode, input int n);
        for (int i = 0; i < n; i++) step(mode, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_val({pfx, "_de"}, int'(vid_out.de), 0);
        check_val({pfx, "_hs"}, int'(vid_out.hs), 0);
        check_val({pfx, "_vs"}, int'(vid_out.vs), 0);
        check_val({pfx, "_r"}, int'(vid_out.r), 0);
        check_val({pfx, "_g"}, int'(vid_out.g), 0);
        check_val({pfx, "_b"}, int'(vid_out.b), 0);
        check_val({pfx, "_mode"}, int'(mode_o), 0);
        check_val({pfx, "_tgl"}, int'(frame_tgl_o), 0);
    endtask

    int px_r[5] = '{255, 0, 0, 255, 0};
    int px_g[5] = '{0, 255, 0, 255, 0};
    int px_b[5] = '{0, 0, 255, 255, 0};
    int px_y[5] = '{77, 149, 29, 255, 0};

    initial begin
        int vs_r, md;
        rst_n = 1'b0;
        mode_i = 2'd0;
        vid_in.de = 1'b0; vid_in.hs = 1'b0; vid_in.vs = 1'b0;
        vid_in.r = 8'd0; vid_in.g = 8'd0; vid_in.b = 8'd0;
        tgl_changes = 0;
        #23;
        check_zero_outputs("reset");
        @(negedge clk);
        release_reset(1);

        // Grey frame with known pixels
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, px_r[i], px_g[i], px_b[i]);
            blanks(1, 3);
            check_val("grey_r", obs_r, px_y[i]);
            check_val("grey_g", obs_g, px_y[i]);
            check_val("grey_b", obs_b, px_y[i]);
        end

        // Inverted grey frame
        step(3, 0, 0, 1, 0, 0, 0);
        step(3, 1, 0, 0, 255, 255, 255);
        blanks(3, 3);
        check_val("inv_white", obs_r, 0);
        step(3, 1, 0, 0, 0, 0, 0);
        blanks(3, 3);
        check_val("inv_black", obs_g, 255);

        // Bypass frame, then a mid-frame request for grey
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 18, 52, 86);
        blanks(0, 3);
        check_val("byp_r", obs_r, 18);
        check_val("byp_g", obs_g, 52);
        check_val("byp_b", obs_b, 86);
        step(1, 1, 0, 0, 18, 52, 86);
        blanks(1, 3);
        check_val("mid_r", obs_r, 18);
        check_val("mid_mode", obs_mode, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 18, 52, 86);
        blanks(1, 3);
        check_val("next_r", obs_r, 46);
        check_val("next_mode", obs_mode, 1);

        // Random timing, pixels and modes
        vs_r = 0;
        md = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(49) == 0) vs_r = 1 - vs_r;
            if ($urandom_range(99) == 0) md = int'($urandom_range(3));
            step(md, int'($urandom_range(1)), int'($urandom_range(1)), vs_r,
                 int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(255)));
        end
        step(md, 0, 0, 0, 0, 0, 0);

        // Async reset in the middle of an active line
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 200, 100, 50);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("arst");
        @(negedge clk);
        release_reset(1);
        step(1, 1, 0, 0, 18, 52, 86);
        blanks(1, 3);
        check_val("post_rst_byp", obs_r, 18);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 18, 52, 86);
        blanks(1, 3);
        check_val("post_rst_grey", obs_r, 46);

        // Auto mode held from reset
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        release_reset(2);
        tgl_changes = 0;
        for (int i = 0; i < 8; i++) begin
            step(2, 0, 0, 1, 0, 0, 0);
            step(2, 1, 0, 0, 255, 0, 0);
            blanks(2, 3);
            check_val("auto_mode", obs_mode, exp_auto[i]);
            check_val("auto_r", obs_r, (exp_auto[i] != 0) ? 77 : 255);
        end
        check_val("auto_toggles", tgl_changes, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
